pp_sd_dma: RTL

PP_SD_DMA -- requirements
Module: pp_sd_dma

---
 rtl/pp_dma_pkg.sv | 21 ++
 rtl/pp_dma_packer.sv | 46 ++++
 rtl/pp_sd_dma.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pp_dma_pkg.sv
// Shared definitions for the SD-sector-to-memory DMA engine: FSM encoding,
// default sector size and small decode helpers.
package pp_dma_pkg;

    localparam int SECTOR_BYTES_DEF = 512;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RECV = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == ST_REQ) || (st == ST_RECV) || (st == ST_NEXT);
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pp_dma_packer.sv
// Collects four SD bytes little-endian into one word and holds the write
// request stable until the memory side accepts it.
module pp_dma_packer
    import pp_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        take,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    input  logic        mem_ready,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        word_done
);

    logic [23:0] acc;

    assign word_done = mem_wr & mem_ready;

    // A take on lane 3 never coincides with a pending word: the top drops
    // sd_byte_ready while mem_wr is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            if (word_done) begin
                mem_wr <= 1'b0;
            end
            if (take) begin
                case (lane)
                    2'd0: acc[7:0]   <= byte_in;
                    2'd1: acc[15:8]  <= byte_in;
                    2'd2: acc[23:16] <= byte_in;
                    default: begin
                        mem_wdata <= {byte_in, acc};
                        mem_wr    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pp_sd_dma.sv
// SD sector read DMA: requests consecutive sectors, packs the incoming byte
// stream into words and writes them to contiguous memory addresses.
//
// state | meaning
// IDLE  | waiting for a dma_en rising edge
// REQ   | sd_rd_req high, waiting for sd_rd_ack
// RECV  | accepting sector bytes and writing packed words
// NEXT  | one cycle: advance sector number, decrement remaining count
// DONE  | dma_done high until dma_en is low
module pp_sd_dma
    import pp_dma_pkg::*;
#(
    parameter int SECTOR_BYTES = SECTOR_BYTES_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_en,
    input  logic [31:0] sd_addr,
    input  logic [31:0] sd_counts,
    input  logic [31:0] dest_addr,
    output logic        sd_rd_req,
    output logic [31:0] sd_rd_sector,
    input  logic        sd_rd_ack,
    input  logic [7:0]  sd_byte,
    input  logic        sd_byte_valid,
    output logic        sd_byte_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam int CW = $clog2(SECTOR_BYTES);
    localparam logic [CW-1:0] LAST_BYTE = CW'(SECTOR_BYTES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [2:0]    state;
    logic          en_q;
    logic [31:0]   sector;
    logic [31:0]   remaining;
    logic [31:0]   rem_dec;
    logic [CW-1:0] byte_cnt;
    logic          bytes_done;
    logic          start;
    logic          take;
    logic          word_done;
    logic          dest_lsb_unused;

    assign dest_lsb_unused = ^dest_addr[1:0];

    assign start         = dma_en & ~en_q & (state == ST_IDLE);
    assign sd_byte_ready = (state == ST_RECV) & ~mem_wr & ~bytes_done;
    assign take          = sd_byte_valid & sd_byte_ready;
    assign rem_dec       = remaining - 32'd1;

    assign sd_rd_req    = (state == ST_REQ);
    assign sd_rd_sector = sector;
    assign dma_busy     = is_busy_state(state);
    assign dma_done     = (state == ST_DONE);

    pp_dma_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .take      (take),
        .lane      (byte_cnt[1:0]),
        .byte_in   (sd_byte),
        .mem_ready (mem_ready),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            en_q       <= 1'b0;
            sector     <= '0;
            remaining  <= '0;
            mem_addr   <= '0;
            byte_cnt   <= '0;
            bytes_done <= 1'b0;
        end else begin
            en_q <= dma_en;

            if (word_done) begin
                mem_addr <= mem_addr + 32'd4;
            end

            // The byte counter wraps at the sector end; bytes_done remembers
            // that the whole sector arrived while its last word drains.
            if (take) begin
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt   <= '0;
                    bytes_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CNT_ONE;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sector     <= sd_addr;
                        remaining  <= sd_counts;
                        mem_addr   <= word_align(dest_addr);
                        byte_cnt   <= '0;
                        bytes_done <= 1'b0;
                        state      <= (sd_counts == 32'd0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sd_rd_ack) begin
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (bytes_done && word_done) begin
                        bytes_done <= 1'b0;
                        state      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    sector    <= sector + 32'd1;
                    remaining <= rem_dec;
                    state     <= (rem_dec != 32'd0) ? ST_REQ : ST_DONE;
                end
                ST_DONE: begin
                    if (!dma_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
